// File: rtl/alif_neuron_multichan_system_pkg.sv
// Shared types and helpers for the multi-channel adaptive LIF neuron.
// Frame geometry, the parameter-set bundle and saturating arithmetic.
package alif_pkg;

    localparam int MAX_CH = 16;
    localparam int MAX_F  = 16;

    typedef enum logic [2:0] {
        F_ADAPT, F_REFRAC, F_LC2, F_LC1, F_THR, F_LR2, F_LR1, F_W
    } field_e;

    // Fields are sized for the widest legal configuration and zero-extended
    typedef struct packed {
        logic [MAX_CH-1:0][MAX_F-1:0] weight;
        logic [MAX_F-1:0]             leak_rate_1;
        logic [MAX_F-1:0]             leak_rate_2;
        logic [MAX_F-1:0]             threshold_min;
        logic [MAX_F-1:0]             leak_cycles_1;
        logic [MAX_F-1:0]             leak_cycles_2;
        logic [MAX_F-1:0]             refrac_cycles;
        logic [MAX_F-1:0]             adapt_step;
    } alif_params_t;

    function automatic int frame_len(int n_ch, int w_w, int leak_w,
                                     int vm_w, int lc_w, int ad_w);
        return n_ch*w_w + 2*leak_w + vm_w + 3*lc_w + ad_w;
    endfunction

    // Bit offset of a field's LSB inside the received frame
    function automatic int field_off(field_e f, int leak_w, int vm_w,
                                     int lc_w, int ad_w);
        int o;
        o = 0;
        case (f)
            F_ADAPT:  o = 0;
            F_REFRAC: o = ad_w;
            F_LC2:    o = ad_w + lc_w;
            F_LC1:    o = ad_w + 2*lc_w;
            F_THR:    o = ad_w + 3*lc_w;
            F_LR2:    o = ad_w + 3*lc_w + vm_w;
            F_LR1:    o = ad_w + 3*lc_w + vm_w + leak_w;
            default:  o = ad_w + 3*lc_w + vm_w + 2*leak_w;
        endcase
        return o;
    endfunction

    function automatic int clamp(int x, int lo, int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    function automatic int sat_add(int a, int b, int hi);
        return clamp(a + b, 0, hi);
    endfunction

    function automatic int sat_sub(int a, int b);
        return (a > b) ? a - b : 0;
    endfunction

endpackage

// File: rtl/alif_neuron_multichan_system_if.sv
// Control, stimulus and status bundle of the adaptive LIF neuron.
interface alif_neuron_multichan_system_if #(
    parameter int N_CH = 4,
    parameter int IN_W = 6,
    parameter int VM_W = 8
);
    logic                 enable;
    logic                 input_enable;
    logic [N_CH*IN_W-1:0] chan_in;
    logic                 load_mode;
    logic                 serial_data;
    logic                 spike_out;
    logic [VM_W-1:0]      v_mem_out;
    logic [VM_W-1:0]      thr_out;
    logic                 params_ready;

    modport master (
        output enable, input_enable, chan_in, load_mode, serial_data,
        input  spike_out, v_mem_out, thr_out, params_ready
    );

    modport slave (
        input  enable, input_enable, chan_in, load_mode, serial_data,
        output spike_out, v_mem_out, thr_out, params_ready
    );
endinterface

// File: rtl/alif_neuron_multichan_loader.sv
// Serial MSB-first parameter loader with abort handling and atomic commit.
module alif_neuron_multichan_loader
    import alif_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int W_W    = 3,
    parameter int VM_W   = 8,
    parameter int LEAK_W = 8,
    parameter int LC_W   = 4,
    parameter int AD_W   = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable_i,
    input  logic         load_mode_i,
    input  logic         serial_data_i,
    output alif_params_t params_o,
    output logic         params_ready_o
);
    localparam int FL    = frame_len(N_CH, W_W, LEAK_W, VM_W, LC_W, AD_W);
    localparam int CW    = $clog2(FL + 1);
    localparam int O_REF = field_off(F_REFRAC, LEAK_W, VM_W, LC_W, AD_W);
    localparam int O_LC2 = field_off(F_LC2, LEAK_W, VM_W, LC_W, AD_W);
    localparam int O_LC1 = field_off(F_LC1, LEAK_W, VM_W, LC_W, AD_W);
    localparam int O_THR = field_off(F_THR, LEAK_W, VM_W, LC_W, AD_W);
    localparam int O_LR2 = field_off(F_LR2, LEAK_W, VM_W, LC_W, AD_W);
    localparam int O_LR1 = field_off(F_LR1, LEAK_W, VM_W, LC_W, AD_W);
    localparam int O_W   = field_off(F_W, LEAK_W, VM_W, LC_W, AD_W);

    logic [FL-2:0] sr_q, sr_d;
    logic [FL-1:0] nsr;
    logic [CW-1:0] cnt_q, cnt_d, base;
    logic          lm_q, lm_d, rdy_q, rdy_d, rise;
    alif_params_t  par_q, par_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        lm_d  = lm_q;
        rdy_d = rdy_q;
        par_d = par_q;
        rise  = load_mode_i && !lm_q;
        base  = rise ? '0 : cnt_q;
        nsr   = {sr_q, serial_data_i};
        if (enable_i) begin
            lm_d = load_mode_i;
            if (rise)
                rdy_d = 1'b0;
            // A finished frame ignores trailing bits until the next rise
            if (load_mode_i && (rise || cnt_q != CW'(FL))) begin
                sr_d  = nsr[FL-2:0];
                cnt_d = base + CW'(1);
                if (cnt_d == CW'(FL)) begin
                    rdy_d = 1'b1;
                    par_d = '0;
                    for (int i = 0; i < N_CH; i++)
                        par_d.weight[i][W_W-1:0] = nsr[O_W + i*W_W +: W_W];
                    par_d.leak_rate_1[LEAK_W-1:0]  = nsr[O_LR1 +: LEAK_W];
                    par_d.leak_rate_2[LEAK_W-1:0]  = nsr[O_LR2 +: LEAK_W];
                    par_d.threshold_min[VM_W-1:0]  = nsr[O_THR +: VM_W];
                    par_d.leak_cycles_1[LC_W-1:0]  = nsr[O_LC1 +: LC_W];
                    par_d.leak_cycles_2[LC_W-1:0]  = nsr[O_LC2 +: LC_W];
                    par_d.refrac_cycles[LC_W-1:0]  = nsr[O_REF +: LC_W];
                    par_d.adapt_step[AD_W-1:0]     = nsr[AD_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
            lm_q  <= 1'b0;
            rdy_q <= 1'b0;
            par_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            lm_q  <= lm_d;
            rdy_q <= rdy_d;
            par_q <= par_d;
        end
    end

    assign params_o       = par_q;
    assign params_ready_o = rdy_q;

endmodule

// File: rtl/alif_neuron_multichan_system.sv
// Multi-channel adaptive LIF neuron core: weighted MAC, dual leak,
// adaptive threshold and refractory period, fed by the serial loader.
module alif_neuron_multichan_system
    import alif_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int IN_W   = 6,
    parameter int W_W    = 3,
    parameter int VM_W   = 8,
    parameter int LEAK_W = 8,
    parameter int LC_W   = 4,
    parameter int AD_W   = 4
) (
    input  logic clk,
    input  logic reset_n,
    alif_neuron_multichan_system_if.slave bus
);
    localparam int VMAX = (1 << VM_W) - 1;

    alif_params_t    prm;
    logic            prm_rdy;
    logic            unused_prm;
    logic [VM_W-1:0] v_q, v_d, ad_q, ad_d, thr_q, thr_d;
    logic [LC_W-1:0] c1_q, c1_d, c2_q, c2_d, rf_q, rf_d;
    logic            spk_q, spk_d, act, t1, t2;
    int              sum, vn, thr_c, lc1, lc2;

    alif_neuron_multichan_loader #(
        .N_CH(N_CH), .W_W(W_W), .VM_W(VM_W),
        .LEAK_W(LEAK_W), .LC_W(LC_W), .AD_W(AD_W)
    ) u_loader (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable_i       (bus.enable),
        .load_mode_i    (bus.load_mode),
        .serial_data_i  (bus.serial_data),
        .params_o       (prm),
        .params_ready_o (prm_rdy)
    );

    assign unused_prm = ^prm;

    always_comb begin
        v_d   = v_q;
        ad_d  = ad_q;
        thr_d = thr_q;
        c1_d  = c1_q;
        c2_d  = c2_q;
        rf_d  = rf_q;
        spk_d = 1'b0;
        act   = bus.enable && prm_rdy;
        sum   = 0;
        for (int i = 0; i < N_CH; i++)
            sum += int'(bus.chan_in[i*IN_W +: IN_W])
                 * int'(prm.weight[i][W_W-1:0]);
        lc1 = int'(prm.leak_cycles_1[LC_W-1:0]);
        lc2 = int'(prm.leak_cycles_2[LC_W-1:0]);
        t1  = (lc1 != 0) && (int'(c1_q) == lc1 - 1);
        t2  = (lc2 != 0) && (int'(c2_q) == lc2 - 1);
        vn  = int'(v_q) + (bus.input_enable ? sum : 0)
            - (t1 ? int'(prm.leak_rate_1[LEAK_W-1:0]) : 0)
            - (t2 ? int'(prm.leak_rate_2[LEAK_W-1:0]) : 0);
        vn  = clamp(vn, 0, VMAX);
        thr_c = sat_add(int'(prm.threshold_min[VM_W-1:0]), int'(ad_q), VMAX);
        if (act) begin
            c1_d = t1 ? '0 : c1_q + LC_W'(1);
            c2_d = t2 ? '0 : c2_q + LC_W'(1);
            if (rf_q != '0) begin
                v_d  = '0;
                rf_d = rf_q - LC_W'(1);
                if (t2)
                    ad_d = VM_W'(sat_sub(int'(ad_q), 1));
            end else if (vn >= thr_c) begin
                v_d   = '0;
                spk_d = 1'b1;
                ad_d  = VM_W'(sat_add(int'(ad_q),
                              int'(prm.adapt_step[AD_W-1:0]), VMAX));
                rf_d  = prm.refrac_cycles[LC_W-1:0];
            end else begin
                v_d = VM_W'(vn);
                if (t2)
                    ad_d = VM_W'(sat_sub(int'(ad_q), 1));
            end
            thr_d = VM_W'(sat_add(int'(prm.threshold_min[VM_W-1:0]),
                                  int'(ad_d), VMAX));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q   <= '0;
            ad_q  <= '0;
            thr_q <= '0;
            c1_q  <= '0;
            c2_q  <= '0;
            rf_q  <= '0;
            spk_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            ad_q  <= ad_d;
            thr_q <= thr_d;
            c1_q  <= c1_d;
            c2_q  <= c2_d;
            rf_q  <= rf_d;
            spk_q <= spk_d;
        end
    end

    assign bus.spike_out    = spk_q;
    assign bus.v_mem_out    = v_q;
    assign bus.thr_out      = thr_q;
    assign bus.params_ready = prm_rdy;

endmodule

// File: tb/tb_alif_neuron_multichan_system.sv
// Directed bench for the adaptive LIF neuron: load/abort, integration,
// refractory, adaptation, saturation, leaks, freeze and async reset.
module tb_alif_neuron_multichan_system;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    alif_neuron_multichan_system_if bus ();

    alif_neuron_multichan_system dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [51:0] frame(
        input logic [2:0] w3, input logic [2:0] w2,
        input logic [2:0] w1, input logic [2:0] w0,
        input logic [7:0] lr1, input logic [7:0] lr2, input logic [7:0] thr,
        input logic [3:0] lc1, input logic [3:0] lc2,
        input logic [3:0] rf, input logic [3:0] ad);
        return {w3, w2, w1, w0, lr1, lr2, thr, lc1, lc2, rf, ad};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [5:0] c0, input logic ie);
        bus.chan_in      = {18'd0, c0};
        bus.input_enable = ie;
    endtask

    task automatic send_bits(input logic [51:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            bus.load_mode   = 1'b1;
            bus.serial_data = f[51-i];
            step();
        end
        bus.load_mode   = 1'b0;
        bus.serial_data = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_in(6'd0, 1'b0);
        bus.enable    = 1'b1;
        bus.load_mode = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic run_seq(input string nm, input logic [51:0] f,
                           input int n, input int ev[], input bit es[]);
        do_reset();
        send_bits(f, 52);
        set_in(6'd10, 1'b1);
        for (int i = 0; i < n; i++) begin
            step();
            total++;
            if (bus.v_mem_out !== 8'(ev[i]) || bus.spike_out !== es[i]) begin
                bad++;
                $display("FAIL %s[%0d]: v=%0d spk=%b, expected v=%0d spk=%b",
                         nm, i, bus.v_mem_out, bus.spike_out, ev[i], es[i]);
            end
        end
    endtask

    task automatic test_reset();
        total += 4;
        if (bus.spike_out !== 1'b0) begin
            bad++; $display("FAIL reset_spike: got %b want 0", bus.spike_out);
        end
        if (bus.v_mem_out !== 8'd0) begin
            bad++; $display("FAIL reset_vmem: got %0d want 0", bus.v_mem_out);
        end
        if (bus.thr_out !== 8'd0) begin
            bad++; $display("FAIL reset_thr: got %0d want 0", bus.thr_out);
        end
        if (bus.params_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready: got %b want 0", bus.params_ready);
        end
    endtask

    task automatic test_load_abort();
        logic [51:0] f1, f2;
        f1 = frame(3'd1, 3'd2, 3'd3, 3'd4, 8'hA5, 8'h3C, 8'd77,
                   4'd9, 4'd6, 4'd2, 4'd11);
        f2 = frame(3'd7, 3'd7, 3'd7, 3'd7, 8'h11, 8'h22, 8'd33,
                   4'd1, 4'd1, 4'd1, 4'd1);
        do_reset();
        for (int i = 0; i < 51; i++) begin
            bus.load_mode   = 1'b1;
            bus.serial_data = f1[51-i];
            step();
        end
        total++;
        if (bus.params_ready !== 1'b0) begin
            bad++; $display("FAIL ready_bit51: got %b want 0", bus.params_ready);
        end
        bus.serial_data = f1[0];
        step();
        bus.load_mode = 1'b0;
        total += 9;
        if (bus.params_ready !== 1'b1) begin
            bad++; $display("FAIL ready_bit52: got %b want 1", bus.params_ready);
        end
        if (dut.prm.weight[0] !== 16'd4 || dut.prm.weight[1] !== 16'd3) begin
            bad++; $display("FAIL w01: got %0d,%0d want 4,3",
                            dut.prm.weight[0], dut.prm.weight[1]);
        end
        if (dut.prm.weight[2] !== 16'd2 || dut.prm.weight[3] !== 16'd1) begin
            bad++; $display("FAIL w23: got %0d,%0d want 2,1",
                            dut.prm.weight[2], dut.prm.weight[3]);
        end
        if (dut.prm.leak_rate_1 !== 16'hA5) begin
            bad++; $display("FAIL lr1: got %h want a5", dut.prm.leak_rate_1);
        end
        if (dut.prm.leak_rate_2 !== 16'h3C) begin
            bad++; $display("FAIL lr2: got %h want 3c", dut.prm.leak_rate_2);
        end
        if (dut.prm.threshold_min !== 16'd77) begin
            bad++; $display("FAIL thr_min: got %0d want 77", dut.prm.threshold_min);
        end
        if (dut.prm.leak_cycles_1 !== 16'd9 || dut.prm.leak_cycles_2 !== 16'd6) begin
            bad++; $display("FAIL lc: got %0d,%0d want 9,6",
                            dut.prm.leak_cycles_1, dut.prm.leak_cycles_2);
        end
        if (dut.prm.refrac_cycles !== 16'd2) begin
            bad++; $display("FAIL refrac: got %0d want 2", dut.prm.refrac_cycles);
        end
        if (dut.prm.adapt_step !== 16'd11) begin
            bad++; $display("FAIL adapt_step: got %0d want 11", dut.prm.adapt_step);
        end
        step();
        step();
        bus.load_mode   = 1'b1;
        bus.serial_data = f2[51];
        step();
        total++;
        if (bus.params_ready !== 1'b0) begin
            bad++; $display("FAIL ready_restart: got %b want 0", bus.params_ready);
        end
        for (int i = 1; i < 30; i++) begin
            bus.serial_data = f2[51-i];
            step();
        end
        bus.load_mode = 1'b0;
        step();
        step();
        total += 3;
        if (bus.params_ready !== 1'b0) begin
            bad++; $display("FAIL ready_abort: got %b want 0", bus.params_ready);
        end
        if (dut.prm.leak_rate_1 !== 16'hA5 || dut.prm.threshold_min !== 16'd77) begin
            bad++; $display("FAIL keep_lr1_thr: got %h,%0d want a5,77",
                            dut.prm.leak_rate_1, dut.prm.threshold_min);
        end
        if (dut.prm.weight[0] !== 16'd4 || dut.prm.adapt_step !== 16'd11) begin
            bad++; $display("FAIL keep_w0_ad: got %0d,%0d want 4,11",
                            dut.prm.weight[0], dut.prm.adapt_step);
        end
    endtask

    task automatic test_integrate();
        run_seq("integrate", frame(3'd1, 3'd1, 3'd1, 3'd1, 8'd0, 8'd0, 8'd40,
                4'd0, 4'd0, 4'd0, 4'd0), 4,
                '{10, 20, 30, 0}, '{0, 0, 0, 1});
        total++;
        if (bus.thr_out !== 8'd40) begin
            bad++; $display("FAIL integ_thr: got %0d want 40", bus.thr_out);
        end
    endtask

    task automatic test_refractory();
        run_seq("refrac", frame(3'd1, 3'd1, 3'd1, 3'd1, 8'd0, 8'd0, 8'd40,
                4'd0, 4'd0, 4'd2, 4'd0), 8,
                '{10, 20, 30, 0, 0, 0, 10, 20}, '{0, 0, 0, 1, 0, 0, 0, 0});
    endtask

    task automatic test_adaptive();
        int et[5];
        int at[5];
        do_reset();
        send_bits(frame(3'd1, 3'd1, 3'd1, 3'd1, 8'd0, 8'd0, 8'd40,
                        4'd0, 4'd3, 4'd0, 4'd5), 52);
        set_in(6'd63, 1'b1);
        step();
        total++;
        if (bus.spike_out !== 1'b1 || bus.thr_out !== 8'd45) begin
            bad++; $display("FAIL adapt_spk1: spk=%b thr=%0d want 1,45",
                            bus.spike_out, bus.thr_out);
        end
        step();
        total++;
        if (bus.spike_out !== 1'b1 || bus.thr_out !== 8'd50) begin
            bad++; $display("FAIL adapt_spk2: spk=%b thr=%0d want 1,50",
                            bus.spike_out, bus.thr_out);
        end
        set_in(6'd0, 1'b0);
        et = '{49, 48, 41, 40, 40};
        at = '{3, 6, 29, 30, 33};
        for (int e = 3, k = 0; e <= 33; e++) begin
            step();
            if (e == at[k]) begin
                total++;
                if (bus.thr_out !== 8'(et[k])) begin
                    bad++; $display("FAIL adapt_decay@%0d: got %0d want %0d",
                                    e, bus.thr_out, et[k]);
                end
                if (k < 4) k++;
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        send_bits(frame(3'd7, 3'd7, 3'd7, 3'd7, 8'd0, 8'd0, 8'd255,
                        4'd0, 4'd0, 4'd0, 4'd15), 52);
        bus.chan_in      = 24'hFFFFFF;
        bus.input_enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (bus.spike_out !== 1'b1 || bus.v_mem_out !== 8'd0
                || bus.thr_out !== 8'd255) begin
                bad++; $display("FAIL sat[%0d]: spk=%b v=%0d thr=%0d want 1,0,255",
                                i, bus.spike_out, bus.v_mem_out, bus.thr_out);
            end
        end
    endtask

    task automatic test_leak();
        run_seq("dual_leak", frame(3'd1, 3'd1, 3'd1, 3'd1, 8'd3, 8'd5, 8'd200,
                4'd2, 4'd4, 4'd0, 4'd0), 4,
                '{10, 17, 27, 29}, '{0, 0, 0, 0});
        run_seq("leak_floor", frame(3'd1, 3'd1, 3'd1, 3'd1, 8'd100, 8'd0, 8'd200,
                4'd4, 4'd0, 4'd0, 4'd0), 4,
                '{10, 20, 30, 0}, '{0, 0, 0, 0});
    endtask

    task automatic test_freeze();
        run_seq("pre_freeze", frame(3'd1, 3'd1, 3'd1, 3'd1, 8'd1, 8'd0, 8'd200,
                4'd3, 4'd0, 4'd0, 4'd0), 2, '{10, 20}, '{0, 0});
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (bus.v_mem_out !== 8'd20 || bus.thr_out !== 8'd200
                || bus.spike_out !== 1'b0) begin
                bad++; $display("FAIL freeze[%0d]: v=%0d thr=%0d spk=%b want 20,200,0",
                                i, bus.v_mem_out, bus.thr_out, bus.spike_out);
            end
        end
        bus.enable = 1'b1;
        step();
        total++;
        if (bus.v_mem_out !== 8'd29) begin
            bad++; $display("FAIL resume_leak: got %0d want 29", bus.v_mem_out);
        end
        step();
        total++;
        if (bus.v_mem_out !== 8'd39) begin
            bad++; $display("FAIL resume_int: got %0d want 39", bus.v_mem_out);
        end
    endtask

    task automatic test_async_reset();
        run_seq("pre_reset", frame(3'd1, 3'd1, 3'd1, 3'd1, 8'd0, 8'd0, 8'd40,
                4'd0, 4'd0, 4'd10, 4'd0), 4,
                '{10, 20, 30, 0}, '{0, 0, 0, 1});
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.spike_out !== 1'b0 || bus.thr_out !== 8'd0
            || bus.v_mem_out !== 8'd0 || bus.params_ready !== 1'b0) begin
            bad++; $display("FAIL async_reset: spk=%b thr=%0d v=%0d rdy=%b want all 0",
                            bus.spike_out, bus.thr_out, bus.v_mem_out,
                            bus.params_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n          = 1'b0;
        bus.enable       = 1'b0;
        bus.input_enable = 1'b0;
        bus.chan_in      = '0;
        bus.load_mode    = 1'b0;
        bus.serial_data  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_load_abort();
        test_integrate();
        test_refractory();
        test_adaptive();
        test_saturation();
        test_leak();
        test_freeze();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alif_neuron_multichan_system.md
# alif_neuron_multichan_system

Parametrised multi-channel adaptive LIF neuron with an integrated serial parameter loader. It is the next generation of the single-channel dual-leak neuron system. It adds:

- N weighted input channels;
- an adaptive threshold that rises on each spike and decays back;
- a programmable refractory period;
- atomic (shadowed) parameter commit.

It sits between the spike-encoding front end and the spike router.

## Interface

Parameters:
- N_CH, 4: number of input channels (1..16)
- IN_W, 6: per-channel input width
- W_W, 3: per-channel weight width
- VM_W, 8: membrane / threshold width
- LEAK_W, 8: leak-rate width
- LC_W, 4: leak-period and refractory-count width
- AD_W, 4: adaptation-step width

Ports:
- clk, in, 1: sole clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: global run. Low freezes all state.
- input_enable, in, 1: integration gate.
- chan_in, in, N_CH*IN_W: channel i occupies bits [i*IN_W +: IN_W]. Unsigned.
- load_mode, in, 1: serial load window.
- serial_data, in, 1: configuration bit, MSB-first.
- spike_out, out, 1: one-cycle spike pulse.
- v_mem_out, out, VM_W: membrane potential.
- thr_out, out, VM_W: current effective threshold.
- params_ready, out, 1: a valid parameter set is committed.

## Operation

Loader:
- Active while enable=1 and load_mode=1. Shifts one bit per cycle into a shift register and increments a bit counter.
- Frame field order, MSB first:
  - weights, ch N_CH-1 down to ch 0, W_W bits each;
  - leak_rate_1, leak_rate_2 (LEAK_W each);
  - threshold_min (VM_W);
  - leak_cycles_1, leak_cycles_2, refrac_cycles (LC_W each);
  - adapt_step (AD_W).
- FRAME_LEN = N_CH*W_W + 2*LEAK_W + VM_W + 3*LC_W + AD_W. This is 52 at the defaults.
- Rising edge of load_mode clears the bit counter and drops params_ready.
- When the counter reaches FRAME_LEN, the shadow registers commit atomically to the active set and params_ready goes to 1. Further bits while load_mode=1 are ignored until the next load_mode rise.
- load_mode falling before FRAME_LEN aborts the load. The partial frame is discarded, the active set is unchanged, and params_ready stays 0 until a full frame commits.

Neuron core:
- Runs only when enable=1 and params_ready=1. Otherwise v_mem, adapt, the counters and refrac are held, and spike_out is 0.
- Integration: sum = Σ chan_i*weight_i, unsigned, width IN_W+W_W+clog2(N_CH). It is added only when input_enable=1 and refrac=0.
- Leak timers:
  - Two free-running counters, cnt1 and cnt2, count active cycles.
  - When cnt1 reaches leak_cycles_1, leak_rate_1 is subtracted and cnt1 clears. The same applies to cnt2 with leak_cycles_2 and leak_rate_2.
  - A period of 0 disables that leak.
  - If both fire in the same cycle, both rates are subtracted.
- Membrane update: v_next = clamp(v_mem + sum − leaks, 0, 2^VM_W−1), computed signed at full width with saturation at both ends.
- Threshold: thr = min(threshold_min + adapt, 2^VM_W−1).
- Spike condition: v_next ≥ thr and refrac=0. On a spike:
  - v_mem ← 0;
  - spike_out ← 1 for one cycle;
  - adapt ← sat(adapt + adapt_step);
  - refrac ← refrac_cycles.
- Refractory: while refrac>0, v_mem is held at 0, input is ignored, and refrac decrements on each active cycle. Leak timers keep counting.
- Adaptation decay: on each leak-2 tick with no spike, adapt decrements by 1, floored at 0. When a spike and a leak-2 tick coincide, the increment wins.

## Timing

- Reset values: spike_out=0, v_mem_out=0, thr_out=0, params_ready=0. All parameters, adapt, refrac, cnt1, cnt2 and the loader counter are 0.
- Integration latency: inputs sampled at edge k appear in v_mem_out after edge k. A spike is visible on spike_out after edge k; v_mem_out reads 0 at the same time.
- Commit latency: the FRAME_LEN-th bit sampled at edge k gives params_ready=1 and new parameters after edge k. The first neuron update using them is at edge k+1.
- A load restarted mid-operation holds the core frozen from the cycle after load_mode rises.
- reset_n asserted mid-frame or mid-refractory returns everything to reset values immediately, without waiting for a clock edge.
- thr_out is registered and updates on the same edge as adapt.

## Structure

- Shared package alif_pkg holds:
  - the FRAME_LEN function and per-field bit-offset functions of the parameters;
  - the parameter-set struct type;
  - saturating add/subtract helper functions.
- Sub-module alif_neuron_multichan_loader contains the shift register, bit counter, abort detection and shadow commit. It outputs the parameter struct plus params_ready.
- The top level holds the neuron core: MAC, leak timers, adaptation and refractory logic.

## Test plan

- **Load / abort:** full 52-bit frame, then a second frame aborted at bit 30.
  - After the first frame: params_ready=1 after bit 52, and all fields read back correctly.
  - On the second frame: params_ready=0 from its start, and the active parameters still equal the first frame.
- **Integrate-to-spike:** weights 1, chan0=10, others 0, both leaks off, threshold_min=40, adapt_step=0, refrac=0.
  - v_mem goes 10, 20, 30, then a spike on the 4th active cycle with v_mem=0.
- **Refractory:** same as above with refrac_cycles=2.
  - After the spike, v_mem stays 0 for 2 cycles, then resumes at 10, 20, …
- **Adaptive threshold:** threshold_min=40, adapt_step=5, leak_cycles_2=3, leak_rate_2=0.
  - thr_out goes to 45 after the first spike and 50 after the second.
  - With no input, it decays by 1 every 3 cycles back to 40.
- **Saturation:** all channels 63, weights 7.
  - v_next clamps at 255. With threshold_min=255 and adapt_step=15, thr_out clamps at 255.
  - Leaks larger than v_mem floor v_mem at 0.
- **Freeze / reset:**
  - enable=0 mid-integration holds v_mem, thr_out and the counters unchanged.
  - reset_n pulsed low mid-refractory zeroes all outputs asynchronously.
